// File: rtl/i2c_slave_if.sv
// I2C bus bundle between an external master (or bench) and the i2c_slave responder.
// Open-drain SDA is modelled as sda_in (line value) plus sda_out/tristate from the slave.
interface i2c_slave_if;
  logic scl;
  logic sda_in;
  logic sda_out;
  logic tristate;

  modport slave (
    input  scl,
    input  sda_in,
    output sda_out,
    output tristate
  );

  modport master (
    output scl,
    output sda_in,
    input  sda_out,
    input  tristate
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C register-file responder: self-test registers, sensor window and WHO_AM_I.
// Optional macro SENSOR_LATCH_EN snapshots sensor_data per read transaction for coherent bursts.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDRESS  = 7'b110_1001,
  parameter logic [7:0] WHO_AM_I_VALUE = 8'h68
) (
  input  logic        clk,
  input  logic        rst,
  i2c_slave_if.slave  bus,
  input  logic [63:0] sensor_data,
  output logic [7:0]  self_test_x,
  output logic [7:0]  self_test_y,
  output logic [7:0]  self_test_z,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic        tristate_q, tristate_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  st_x_q, st_x_d, st_y_q, st_y_d, st_z_q, st_z_d;
  logic [63:0] rd_src;
  logic [7:0]  rd_byte;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

`ifdef SENSOR_LATCH_EN
  logic [63:0] shadow_q, shadow_d;
  assign rd_src = shadow_q;
`else
  assign rd_src = sensor_data;
`endif

  always_comb begin
    rd_byte = '0;
    case (ptr_q)
      8'h0D:   rd_byte = st_x_q;
      8'h0E:   rd_byte = st_y_q;
      8'h0F:   rd_byte = st_z_q;
      8'h41:   rd_byte = rd_src[63:56];
      8'h42:   rd_byte = rd_src[55:48];
      8'h43:   rd_byte = rd_src[47:40];
      8'h44:   rd_byte = rd_src[39:32];
      8'h45:   rd_byte = rd_src[31:24];
      8'h46:   rd_byte = rd_src[23:16];
      8'h47:   rd_byte = rd_src[15:8];
      8'h48:   rd_byte = rd_src[7:0];
      8'h75:   rd_byte = WHO_AM_I_VALUE;
      default: rd_byte = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    tristate_d = tristate_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    st_x_d     = st_x_q;
    st_y_d     = st_y_q;
    st_z_d     = st_z_q;
`ifdef SENSOR_LATCH_EN
    shadow_d   = shadow_q;
`endif

    if (stop_det) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      tristate_d = 1'b1;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      tristate_d = 1'b1;
    end else begin
      case (state_q)
        ADDR, REG, WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d  = '0;
            tristate_d = 1'b0;
            case (state_q)
              ADDR: begin
                if (shift_q[7:1] == SLAVE_ADDRESS) begin
                  rw_d    = shift_q[0];
                  busy_d  = 1'b1;
                  state_d = ADDR_ACK;
`ifdef SENSOR_LATCH_EN
                  if (shift_q[0]) shadow_d = sensor_data;
`endif
                end else begin
                  tristate_d = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
                end
              end
              REG: begin
                ptr_d   = shift_q;
                state_d = REG_ACK;
              end
              default: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = shift_q;
                if (ptr_q == 8'h0D) st_x_d = shift_q;
                if (ptr_q == 8'h0E) st_y_d = shift_q;
                if (ptr_q == 8'h0F) st_z_d = shift_q;
                ptr_d   = ptr_q + 8'd1;
                state_d = WDATA_ACK;
              end
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_d       = rd_byte[6:0];
              tristate_d = rd_byte[7];
              state_d    = RDATA;
            end else begin
              tristate_d = 1'b1;
              state_d    = REG;
            end
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            tristate_d = 1'b1;
            state_d    = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d  = '0;
              tristate_d = 1'b1;
              ptr_d      = ptr_q + 8'd1;
              state_d    = RDATA_ACK;
            end else begin
              // A 1 bit is sent by releasing the line, so the bit value is the tristate value.
              tristate_d = tx_q[6];
              tx_d       = {tx_q[5:0], 1'b1};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (!ack_q) begin
              tx_d       = rd_byte[6:0];
              tristate_d = rd_byte[7];
              state_d    = RDATA;
            end else begin
              tristate_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '1;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      tristate_q <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      st_x_q     <= '0;
      st_y_q     <= '0;
      st_z_q     <= '0;
`ifdef SENSOR_LATCH_EN
      shadow_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[0], bus.scl};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      tristate_q <= tristate_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      st_x_q     <= st_x_d;
      st_y_q     <= st_y_d;
      st_z_q     <= st_z_d;
`ifdef SENSOR_LATCH_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign bus.sda_out  = 1'b0;
  assign bus.tristate = tristate_q;
  assign busy         = busy_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign self_test_x  = st_x_q;
  assign self_test_y  = st_y_q;
  assign self_test_z  = st_z_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master, table of single-byte transactions
// plus hand sequences for reset mid-write, pointer wrap and burst reads.
module tb_i2c_slave;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [63:0] sensor_data;
  logic [7:0]  self_test_x, self_test_y, self_test_z;
  logic        wr_valid, busy;
  logic [7:0]  wr_addr, wr_data;

  int checks = 0;
  int failures = 0;
  int drive_cnt = 0;
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];

  i2c_slave_if bus ();
  assign bus.scl    = m_scl;
  assign bus.sda_in = m_sda & (bus.tristate | bus.sda_out);

  i2c_slave dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sensor_data (sensor_data),
    .self_test_x (self_test_x),
    .self_test_y (self_test_y),
    .self_test_z (self_test_z),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (!bus.tristate) drive_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    b = bus.sda_in; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read8(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  typedef struct {
    logic [6:0] dev;
    logic       rd;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       ack;
    logic [7:0] exp_rd;
    logic [7:0] ex, ey, ez;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] exp_b;
    int         n0, dc0;

    vecs[0]  = '{7'h69, 1'b0, 8'h0D, 8'h03, 1'b1, 8'h00, 8'h03, 8'h00, 8'h00};
    vecs[1]  = '{7'h69, 1'b1, 8'h75, 8'h00, 1'b1, 8'h68, 8'h03, 8'h00, 8'h00};
    vecs[2]  = '{7'h68, 1'b0, 8'h0D, 8'hEE, 1'b0, 8'h00, 8'h03, 8'h00, 8'h00};
    vecs[3]  = '{7'h69, 1'b0, 8'h0E, 8'hA5, 1'b1, 8'h00, 8'h03, 8'hA5, 8'h00};
    vecs[4]  = '{7'h69, 1'b0, 8'h0F, 8'h5A, 1'b1, 8'h00, 8'h03, 8'hA5, 8'h5A};
    vecs[5]  = '{7'h69, 1'b1, 8'h0E, 8'h00, 1'b1, 8'hA5, 8'h03, 8'hA5, 8'h5A};
    vecs[6]  = '{7'h69, 1'b0, 8'h20, 8'h77, 1'b1, 8'h00, 8'h03, 8'hA5, 8'h5A};
    vecs[7]  = '{7'h69, 1'b1, 8'h20, 8'h00, 1'b1, 8'h00, 8'h03, 8'hA5, 8'h5A};
    vecs[8]  = '{7'h69, 1'b1, 8'h43, 8'h00, 1'b1, 8'h03, 8'h03, 8'hA5, 8'h5A};
    vecs[9]  = '{7'h69, 1'b1, 8'h0D, 8'h00, 1'b1, 8'h03, 8'h03, 8'hA5, 8'h5A};
    vecs[10] = '{7'h29, 1'b1, 8'h0D, 8'h00, 1'b0, 8'h00, 8'h03, 8'hA5, 8'h5A};

    sensor_data = 64'h0102_0304_0506_0708;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tristate", bus.tristate, 1'b1);
    check("rst_sda_out", bus.sda_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_st", {self_test_x, self_test_y, self_test_z}, 24'h0);
    rst = 1'b1;
    #Q;

    // Reset asserted during the 5th data bit of a write to 0x0E
    n0 = wa_q.size();
    i2c_start();
    write_byte(8'hD2, ack); check("rstw_addr_ack", ack, 1'b0);
    write_byte(8'h0E, ack); check("rstw_reg_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #(Q/2);
    check("rstw_busy_before", busy, 1'b1);
    rst = 1'b0;
    #20;
    check("rstw_tristate", bus.tristate, 1'b1);
    check("rstw_busy", busy, 1'b0);
    check("rstw_st_y", self_test_y, 8'h00);
    m_scl = 1'b1; m_sda = 1'b1;
    #Q;
    check("rstw_no_write", wa_q.size() - n0, 0);
    rst = 1'b1;
    #Q;

    // Table of single-byte transactions
    for (int v = 0; v < 11; v++) begin
      n0  = wa_q.size();
      dc0 = drive_cnt;
      i2c_start();
      write_byte({vecs[v].dev, 1'b0}, ack);
      check($sformatf("v%0d_addr_ack", v), ack, !vecs[v].ack);
      if (vecs[v].ack) begin
        check($sformatf("v%0d_busy", v), busy, 1'b1);
        write_byte(vecs[v].rg, ack);
        check($sformatf("v%0d_reg_ack", v), ack, 1'b0);
        if (vecs[v].rd) begin
          i2c_start();
          write_byte({vecs[v].dev, 1'b1}, ack);
          check($sformatf("v%0d_raddr_ack", v), ack, 1'b0);
          read8(d);
          write_bit(1'b1);
          check($sformatf("v%0d_rdata", v), d, vecs[v].exp_rd);
        end else begin
          write_byte(vecs[v].wd, ack);
          check($sformatf("v%0d_data_ack", v), ack, 1'b0);
        end
        i2c_stop();
        #Q;
        check($sformatf("v%0d_busy_after", v), busy, 1'b0);
        if (!vecs[v].rd) begin
          check($sformatf("v%0d_wr_count", v), wa_q.size() - n0, 1);
          if (wa_q.size() > n0) begin
            check($sformatf("v%0d_wr_addr", v), wa_q[n0], vecs[v].rg);
            check($sformatf("v%0d_wr_data", v), wd_q[n0], vecs[v].wd);
          end
        end else begin
          check($sformatf("v%0d_wr_count", v), wa_q.size() - n0, 0);
        end
      end else begin
        check($sformatf("v%0d_busy", v), busy, 1'b0);
        i2c_stop();
        #Q;
        check($sformatf("v%0d_never_drove", v), drive_cnt - dc0, 0);
        check($sformatf("v%0d_wr_count", v), wa_q.size() - n0, 0);
      end
      check($sformatf("v%0d_st", v), {self_test_x, self_test_y, self_test_z},
            {vecs[v].ex, vecs[v].ey, vecs[v].ez});
    end

    // Pointer wrap on consecutive writes from 0xFF
    n0 = wa_q.size();
    i2c_start();
    write_byte(8'hD2, ack); check("wrap_addr_ack", ack, 1'b0);
    write_byte(8'hFF, ack); check("wrap_reg_ack", ack, 1'b0);
    write_byte(8'h11, ack); check("wrap_d0_ack", ack, 1'b0);
    write_byte(8'h22, ack); check("wrap_d1_ack", ack, 1'b0);
    i2c_stop();
    #Q;
    check("wrap_count", wa_q.size() - n0, 2);
    if (wa_q.size() >= n0 + 2) begin
      check("wrap_addr0", wa_q[n0], 8'hFF);
      check("wrap_addr1", wa_q[n0+1], 8'h00);
      check("wrap_data1", wd_q[n0+1], 8'h22);
    end

    // Burst read of the sensor window with a mid-burst sensor update
    i2c_start();
    write_byte(8'hD2, ack); check("burst_addr_ack", ack, 1'b0);
    write_byte(8'h41, ack); check("burst_reg_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hD3, ack); check("burst_raddr_ack", ack, 1'b0);
    for (int k = 0; k < 8; k++) begin
      read8(d);
      if (k == 3) sensor_data = 64'h1112_1314_1516_1718;
      write_bit(k == 7);
      exp_b = 8'h01 + 8'(k);
`ifndef SENSOR_LATCH_EN
      if (k >= 4) exp_b = 8'h11 + 8'(k);
`endif
      check($sformatf("burst_byte%0d", k), d, exp_b);
    end
    check("burst_busy", busy, 1'b1);
    i2c_stop();
    #Q;
    check("burst_busy_after", busy, 1'b0);
    check("burst_tristate_after", bus.tristate, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDRESS, default 7'b110_1001; the 7-bit address this responder answers to.
REQ-002 Parameter WHO_AM_I_VALUE, default 8'h68; read-only content of register 8'h75.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 scl  input  1  I2C clock from master, asynchronous to clk.
REQ-006 sda_in  input  1  sampled SDA line.
REQ-007 sda_out  output  1  value driven onto SDA when tristate=0; held at 0.
REQ-008 tristate  output  1  1 = SDA released (high-Z), 0 = drive sda_out.
REQ-009 sensor_data  input  64  {TEMP_H, TEMP_L, GYRO_XH, GYRO_XL, GYRO_YH, GYRO_YL, GYRO_ZH, GYRO_ZL}; MSB byte maps to 8'h41, LSB byte to 8'h48.
REQ-010 self_test_x/y/z  output  8 each  contents of registers 8'h0D/8'h0E/8'h0F.
REQ-011 wr_valid  output  1  one-clk pulse per accepted write byte.
REQ-012 wr_addr, wr_data  output  8 each  register pointer and byte of the accepted write; valid with wr_valid.
REQ-013 busy  output  1  high from matched address through STOP.

Function
REQ-014 scl and sda_in shall pass through 2-flop synchronizers; edges are detected on the synchronized values; clk shall be at least 16x the SCL frequency.
REQ-015 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are honoured in every state.
REQ-016 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 START in any state -> ADDR with bit counter cleared (repeated START supported); STOP in any state -> IDLE with tristate=1.
REQ-018 Bits are sampled on SCL rising edge, MSB first; SDA is driven or released only after an SCL falling edge.
REQ-019 ADDR: 8 bits shifted; on address match ACK (drive 0 for the 9th clock), then R/W=0 -> REG, R/W=1 -> RDATA; on mismatch release SDA and return to IDLE.
REQ-020 REG: 8-bit register pointer loaded, ACKed, then WDATA.
REQ-021 WDATA: each byte ACKed; writes to 8'h0D-8'h0F update the matching self_test register; every byte pulses wr_valid with the current pointer; writes to any other address are ACKed and discarded.
REQ-022 RDATA: byte for current pointer loaded at the SCL falling edge that ends ACK; 8'h0D-0F = self_test, 8'h41-48 = sensor_data bytes, 8'h75 = WHO_AM_I_VALUE, all other addresses = 8'h00.
REQ-023 RDATA_ACK: release SDA; master ACK (0) -> RDATA with next byte; NACK (1) -> IDLE.
REQ-024 Register pointer increments after every data byte (read or write) and wraps 8'hFF -> 8'h00.
REQ-025 Slave drives only 0 (open-drain); a 1 bit is sent as tristate=1.

Reset
REQ-026 rst low shall immediately force: state IDLE, tristate=1, sda_out=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, pointer=0, self_test_x/y/z=0, synchronizers to 1.
REQ-027 Reset mid-transfer abandons the transaction; no partial write is committed.

Configuration
REQ-028 Macro SENSOR_LATCH_EN defined: sensor_data is captured into a 64-bit shadow on a matched read address, and all read bytes of that transaction come from the shadow (coherent multi-byte read).
REQ-029 SENSOR_LATCH_EN undefined: each read byte is taken from live sensor_data when loaded; no shadow register exists.

Verification
REQ-030 Write 0x69/W, reg 8'h0D, data 8'h03 -> three ACKs, self_test_x=8'h03, one wr_valid with wr_addr=8'h0D, wr_data=8'h03.
REQ-031 Write 0x69/W reg 8'h75, repeated START, 0x69/R, NACK -> data byte 8'h68.
REQ-032 Address 0x68/W -> SDA never driven, state returns IDLE, busy stays 0.
REQ-033 sensor_data=64'h0102_0304_0506_0708; pointer 8'h41, read 8 bytes with ACK except last -> 01..08 in order; with SENSOR_LATCH_EN, changing sensor_data mid-burst leaves the returned bytes unchanged.
REQ-034 Pointer 8'hFF, write 2 bytes -> second wr_addr=8'h00.
REQ-035 Assert rst during the 5th data bit of a write to 8'h0E -> tristate=1, self_test_y remains 8'h00.
